// File: rtl/gpio_pin_ctrl.sv
// gpio_pin_ctrl: pad-side GPIO stage.
//   Registers the output data/enable taken from the register block, synchronises
//   and glitch-filters the raw pad inputs, and latches per-pin change events into
//   a pending vector that drives a single interrupt request.
// Ports:
//   clk, reset                 clock, asynchronous active-high reset
//   rf_gpio_datareg[15:0]      data to drive on the pads
//   rf_gpio_tristate[15:0]     1 = hi-Z/input, 0 = driven output
//   rf_gpio_interrupt_mask     per-pin interrupt enable
//   int_clr[15:0]              write-1-to-clear pulse for int_pending
//   gpio_in[15:0]              raw pad input (asynchronous to clk)
//   gpio_out, gpio_oe          registered pad data / output enable
//   ro_gpio_pinstate           filtered pin state back to the register block
//   int_pending                latched change events
//   irq                        OR of enabled pending bits
module gpio_pin_ctrl #(
    parameter int unsigned FILTER_CYCLES = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] rf_gpio_datareg,
    input  logic [15:0] rf_gpio_tristate,
    input  logic [15:0] rf_gpio_interrupt_mask,
    input  logic [15:0] int_clr,
    input  logic [15:0] gpio_in,
    output logic [15:0] gpio_out,
    output logic [15:0] gpio_oe,
    output logic [15:0] ro_gpio_pinstate,
    output logic [15:0] int_pending,
    output logic        irq
);

    localparam logic [7:0] CNT_LAST = 8'(FILTER_CYCLES - 1);

    logic [15:0] s1;
    logic [15:0] s2;
    logic [15:0] filt;
    logic [7:0]  cnt [16];
    logic [15:0] upd;

    // Output path: plain registers, independent of the input path.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            gpio_out <= '0;
            gpio_oe  <= '0;
        end else begin
            gpio_out <= rf_gpio_datareg;
            gpio_oe  <= ~rf_gpio_tristate;
        end
    end

    // Two-flop synchroniser for the asynchronous pad inputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1 <= '0;
            s2 <= '0;
        end else begin
            s1 <= gpio_in;
            s2 <= s1;
        end
    end

    // A pin updates when it has differed from the filtered value for
    // FILTER_CYCLES consecutive cycles (counter already at its last value).
    always_comb begin
        upd = '0;
        for (int unsigned i = 0; i < 16; i++) begin
            upd[i] = (s2[i] != filt[i]) && (cnt[i] == CNT_LAST);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            filt <= '0;
            for (int unsigned i = 0; i < 16; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            for (int unsigned i = 0; i < 16; i++) begin
                if (s2[i] == filt[i]) begin
                    cnt[i] <= '0;
                end else if (upd[i]) begin
                    filt[i] <= s2[i];
                    cnt[i]  <= '0;
                end else begin
                    cnt[i] <= cnt[i] + 8'd1;
                end
            end
        end
    end

    // Set has priority over a coincident clear.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            int_pending <= '0;
        end else begin
            int_pending <= (int_pending & ~int_clr) | (upd & rf_gpio_interrupt_mask);
        end
    end

    assign ro_gpio_pinstate = filt;
    assign irq              = |(int_pending & rf_gpio_interrupt_mask);

endmodule

// File: tb/tb_gpio_pin_ctrl.sv
module tb_gpio_pin_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] rf_gpio_datareg;
    logic [15:0] rf_gpio_tristate;
    logic [15:0] rf_gpio_interrupt_mask;
    logic [15:0] int_clr;
    logic [15:0] gpio_in;
    logic [15:0] gpio_out;
    logic [15:0] gpio_oe;
    logic [15:0] ro_gpio_pinstate;
    logic [15:0] int_pending;
    logic        irq;

    gpio_pin_ctrl #(.FILTER_CYCLES(4)) dut (
        .clk                    (clk),
        .reset                  (reset),
        .rf_gpio_datareg        (rf_gpio_datareg),
        .rf_gpio_tristate       (rf_gpio_tristate),
        .rf_gpio_interrupt_mask (rf_gpio_interrupt_mask),
        .int_clr                (int_clr),
        .gpio_in                (gpio_in),
        .gpio_out               (gpio_out),
        .gpio_oe                (gpio_oe),
        .ro_gpio_pinstate       (ro_gpio_pinstate),
        .int_pending            (int_pending),
        .irq                    (irq)
    );

    always #5 clk = ~clk;

    localparam int SEL_OUT  = 0;
    localparam int SEL_OE   = 1;
    localparam int SEL_PIN  = 2;
    localparam int SEL_PEND = 3;
    localparam int SEL_IRQ  = 4;

    typedef struct {
        string       tag;
        int          sel;
        logic [15:0] exp;
    } sb_entry_t;

    sb_entry_t sb[$];
    int passed = 0;
    int total  = 0;

    function automatic logic [15:0] observe(input int sel);
        case (sel)
            SEL_OUT:  return gpio_out;
            SEL_OE:   return gpio_oe;
            SEL_PIN:  return ro_gpio_pinstate;
            SEL_PEND: return int_pending;
            default:  return {15'b0, irq};
        endcase
    endfunction

    task automatic push(input string tag, input int sel, input logic [15:0] v);
        sb_entry_t e;
        e.tag = tag;
        e.sel = sel;
        e.exp = v;
        sb.push_back(e);
    endtask

    task automatic drain();
        sb_entry_t   e;
        logic [15:0] o;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            o = observe(e.sel);
            total++;
            assert (o === e.exp) begin
                passed++;
            end else begin
                $error("FAIL %s observed=%h expected=%h", e.tag, o, e.exp);
            end
        end
    endtask

    // Advance n rising edges, then settle 1 time unit past the last one.
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        reset                  = 1'b1;
        rf_gpio_datareg        = 16'h0000;
        rf_gpio_tristate       = 16'hFFFF;
        rf_gpio_interrupt_mask = 16'h0000;
        int_clr                = 16'h0000;
        gpio_in                = 16'hFFFF;

        // Reset with pads high and mask clear.
        tick(2);
        push("rst_out", SEL_OUT, 16'h0000);
        push("rst_oe", SEL_OE, 16'h0000);
        push("rst_pin", SEL_PIN, 16'h0000);
        push("rst_pend", SEL_PEND, 16'h0000);
        push("rst_irq", SEL_IRQ, 16'h0000);
        drain();
        reset = 1'b0;
        push("rel_pin_c5", SEL_PIN, 16'h0000);
        tick(5);
        drain();
        push("rel_pin_c6", SEL_PIN, 16'hFFFF);
        push("rel_pend", SEL_PEND, 16'h0000);
        tick(1);
        drain();
        gpio_in = 16'h0000;
        push("rel_pin_back", SEL_PIN, 16'h0000);
        push("rel_pend_back", SEL_PEND, 16'h0000);
        tick(8);
        drain();

        // Output path.
        rf_gpio_tristate = 16'h00FF;
        rf_gpio_datareg  = 16'hA5A5;
        push("oe", SEL_OE, 16'hFF00);
        push("out", SEL_OUT, 16'hA5A5);
        tick(1);
        drain();

        // 3-cycle glitch on pin 3 is rejected.
        rf_gpio_interrupt_mask = 16'h0008;
        gpio_in[3] = 1'b1;
        tick(3);
        gpio_in[3] = 1'b0;
        for (int i = 0; i < 8; i++) begin
            push("glitch_pin", SEL_PIN, 16'h0000);
            push("glitch_irq", SEL_IRQ, 16'h0000);
            tick(1);
            drain();
        end

        // 4-cycle pulse on pin 3 is accepted at cycle 6.
        gpio_in[3] = 1'b1;
        tick(4);
        gpio_in[3] = 1'b0;
        push("p4_pin_c5", SEL_PIN, 16'h0000);
        push("p4_irq_c5", SEL_IRQ, 16'h0000);
        tick(1);
        drain();
        push("p4_pin_c6", SEL_PIN, 16'h0008);
        push("p4_pend_c6", SEL_PEND, 16'h0008);
        push("p4_irq_c6", SEL_IRQ, 16'h0001);
        tick(1);
        drain();
        push("p4_fall_pin", SEL_PIN, 16'h0000);
        push("p4_fall_pend", SEL_PEND, 16'h0008);
        tick(4);
        drain();
        int_clr = 16'h0008;
        push("p4_clr_pend", SEL_PEND, 16'h0000);
        tick(1);
        int_clr = 16'h0000;
        drain();

        // Pin 5: clear, then clear coincident with a new update.
        rf_gpio_interrupt_mask = 16'h0020;
        gpio_in[5] = 1'b1;
        push("p5_pend", SEL_PEND, 16'h0020);
        push("p5_irq", SEL_IRQ, 16'h0001);
        tick(6);
        drain();
        int_clr = 16'h0020;
        push("p5_clr_pend", SEL_PEND, 16'h0000);
        push("p5_clr_irq", SEL_IRQ, 16'h0000);
        tick(1);
        int_clr = 16'h0000;
        drain();
        gpio_in[5] = 1'b0;
        tick(5);
        int_clr = 16'h0020;
        push("p5_setwin_pend", SEL_PEND, 16'h0020);
        push("p5_setwin_pin", SEL_PIN, 16'h0000);
        tick(1);
        int_clr = 16'h0000;
        drain();
        int_clr = 16'h0020;
        tick(1);
        int_clr = 16'h0000;

        // Pin 7: mask gates irq only; masked updates are discarded.
        rf_gpio_interrupt_mask = 16'h0080;
        gpio_in[7] = 1'b1;
        push("p7_pend", SEL_PEND, 16'h0080);
        tick(6);
        drain();
        rf_gpio_interrupt_mask = 16'h0000;
        #1;
        push("p7_mask_irq", SEL_IRQ, 16'h0000);
        push("p7_mask_pend", SEL_PEND, 16'h0080);
        drain();
        rf_gpio_interrupt_mask = 16'h0080;
        #1;
        push("p7_unmask_irq", SEL_IRQ, 16'h0001);
        drain();
        int_clr = 16'h0080;
        tick(1);
        int_clr = 16'h0000;
        rf_gpio_interrupt_mask = 16'h0000;
        gpio_in[7] = 1'b0;
        tick(8);
        rf_gpio_interrupt_mask = 16'h0080;
        #1;
        push("p7_discard_pin", SEL_PIN, 16'h0000);
        push("p7_discard_pend", SEL_PEND, 16'h0000);
        push("p7_discard_irq", SEL_IRQ, 16'h0000);
        drain();

        // Pins 0 and 15 together.
        rf_gpio_interrupt_mask = 16'h8001;
        gpio_in = 16'h8001;
        push("p015_pend_c5", SEL_PEND, 16'h0000);
        tick(5);
        drain();
        push("p015_pend_c6", SEL_PEND, 16'h8001);
        push("p015_pin_c6", SEL_PIN, 16'h8001);
        tick(1);
        drain();
        int_clr = 16'h0001;
        push("p015_clr_pend", SEL_PEND, 16'h8000);
        push("p015_clr_irq", SEL_IRQ, 16'h0001);
        tick(1);
        int_clr = 16'h0000;
        drain();

        // Output registers still hold the earlier values.
        push("out_hold", SEL_OUT, 16'hA5A5);
        push("oe_hold", SEL_OE, 16'hFF00);
        drain();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
